// File: rtl/timer_cmp_irq_if.sv
// Bus bundle between the APB register file / counter stage and timer_cmp_irq.
// master drives count and the write strobes; slave returns readback and interrupt.
interface timer_cmp_irq_if;
   logic [63:0] count;
   logic        wr_CMP0;
   logic        wr_CMP1;
   logic        wr_INT_EN;
   logic        wr_INT_ST;
   logic [3:0]  pstrb;
   logic [31:0] wdata;
   logic [63:0] cmp;
   logic        int_en;
   logic        int_st;
   logic        cmp_hit;
   logic        tim_int;

   modport master (
      output count, wr_CMP0, wr_CMP1, wr_INT_EN, wr_INT_ST, pstrb, wdata,
      input  cmp, int_en, int_st, cmp_hit, tim_int
   );

   modport slave (
      input  count, wr_CMP0, wr_CMP1, wr_INT_EN, wr_INT_ST, pstrb, wdata,
      output cmp, int_en, int_st, cmp_hit, tim_int
   );
endinterface

// File: rtl/timer_cmp_irq.sv
// 64-bit compare register with sticky W1C interrupt status and enable mask.
// Define TIMER_CMP_GE_EN to match on count >= cmp instead of count == cmp.
module timer_cmp_irq (
   input logic            clk,
   input logic            rst_n,
   timer_cmp_irq_if.slave bus
);

   logic [63:0] r_cmp;
   logic        r_int_en;
   logic        r_int_st;
   logic        r_cmp_hit;
   logic        r_tim_int;

   logic [63:0] w_cmp_nxt;
   logic        w_en_nxt;
   logic        w_st_nxt;
   logic        w_match;
   logic        w_clr;

   function automatic logic [31:0] f_byte_merge(
      input logic [31:0] i_old,
      input logic [31:0] i_new,
      input logic [3:0]  i_strb
   );
      logic [31:0] v_word;
      v_word = i_old;
      for (int b = 0; b < 4; b++) begin
         if (i_strb[b]) begin
            v_word[b*8 +: 8] = i_new[b*8 +: 8];
         end else begin
            v_word[b*8 +: 8] = i_old[b*8 +: 8];
         end
      end
      return v_word;
   endfunction

   // Compare against the registered value, so a write cycle still uses the old cmp.
   always_comb begin
      w_match = 1'b0;
`ifdef TIMER_CMP_GE_EN
      w_match = (bus.count >= r_cmp);
`else
      w_match = (bus.count == r_cmp);
`endif
   end

   // Next-state for compare, enable and sticky status.
   always_comb begin
      w_cmp_nxt = r_cmp;
      if (bus.wr_CMP0) begin
         w_cmp_nxt[31:0] = f_byte_merge(r_cmp[31:0], bus.wdata, bus.pstrb);
      end else begin
         w_cmp_nxt[31:0] = r_cmp[31:0];
      end
      if (bus.wr_CMP1) begin
         w_cmp_nxt[63:32] = f_byte_merge(r_cmp[63:32], bus.wdata, bus.pstrb);
      end else begin
         w_cmp_nxt[63:32] = r_cmp[63:32];
      end

      if (bus.wr_INT_EN && bus.pstrb[0]) begin
         w_en_nxt = bus.wdata[0];
      end else begin
         w_en_nxt = r_int_en;
      end

      w_clr    = bus.wr_INT_ST & bus.pstrb[0] & bus.wdata[0];
      w_st_nxt = w_match | (r_int_st & ~w_clr);
   end

   // State registers; tim_int is registered from next values so it equals int_en & int_st.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmp     <= 64'hFFFF_FFFF_FFFF_FFFF;
         r_int_en  <= 1'b0;
         r_int_st  <= 1'b0;
         r_cmp_hit <= 1'b0;
         r_tim_int <= 1'b0;
      end else begin
         r_cmp     <= w_cmp_nxt;
         r_int_en  <= w_en_nxt;
         r_int_st  <= w_st_nxt;
         r_cmp_hit <= w_st_nxt & ~r_int_st;
         r_tim_int <= w_en_nxt & w_st_nxt;
      end
   end

   assign bus.cmp     = r_cmp;
   assign bus.int_en  = r_int_en;
   assign bus.int_st  = r_int_st;
   assign bus.cmp_hit = r_cmp_hit;
   assign bus.tim_int = r_tim_int;

endmodule

// File: tb/tb_timer_cmp_irq.sv
// Directed and randomized bench for timer_cmp_irq against a behavioural model.
module tb_timer_cmp_irq;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   timer_cmp_irq_if bus ();

   timer_cmp_irq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d passed=%0d", n_checks, n_pass);
      $fatal(1, "watchdog");
   end

   // Reference state, written from the register-level rules.
   logic [63:0] m_cmp;
   logic        m_en;
   logic        m_st;
   logic        m_hit;

   task automatic model_reset();
      m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
      m_en  = 1'b0;
      m_st  = 1'b0;
      m_hit = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_all();
      chk("cmp",     bus.cmp,            m_cmp);
      chk("int_en",  {63'd0, bus.int_en},  {63'd0, m_en});
      chk("int_st",  {63'd0, bus.int_st},  {63'd0, m_st});
      chk("cmp_hit", {63'd0, bus.cmp_hit}, {63'd0, m_hit});
      chk("tim_int", {63'd0, bus.tim_int}, {63'd0, m_en & m_st});
   endtask

   task automatic idle();
      bus.wr_CMP0   = 1'b0;
      bus.wr_CMP1   = 1'b0;
      bus.wr_INT_EN = 1'b0;
      bus.wr_INT_ST = 1'b0;
      bus.pstrb     = 4'h0;
      bus.wdata     = 32'h0;
   endtask

   // One clock: model advances from the inputs present before the edge.
   task automatic cycle();
      logic        match;
      logic        clr;
      logic        st_new;
      logic [63:0] cmp_new;
      bit          hi;
`ifdef TIMER_CMP_GE_EN
      match = (bus.count >= m_cmp);
`else
      match = (bus.count == m_cmp);
`endif
      clr    = bus.wr_INT_ST && bus.pstrb[0] && bus.wdata[0];
      st_new = match || (m_st && !clr);
      cmp_new = m_cmp;
      for (int b = 0; b < 8; b++) begin
         hi = (b >= 4);
         if (((hi && bus.wr_CMP1) || (!hi && bus.wr_CMP0)) && bus.pstrb[b % 4])
            cmp_new[b*8 +: 8] = bus.wdata[(b % 4)*8 +: 8];
      end
      @(posedge clk);
      #1;
      m_hit = st_new && !m_st;
      m_st  = st_new;
      m_cmp = cmp_new;
      if (bus.wr_INT_EN && bus.pstrb[0]) m_en = bus.wdata[0];
      check_all();
   endtask

   task automatic wr_cmp(input bit hi, input logic [3:0] strb, input logic [31:0] d);
      idle();
      bus.wr_CMP0 = !hi;
      bus.wr_CMP1 = hi;
      bus.pstrb   = strb;
      bus.wdata   = d;
      cycle();
      idle();
   endtask

   task automatic wr_en(input logic v);
      idle();
      bus.wr_INT_EN = 1'b1;
      bus.pstrb     = 4'h1;
      bus.wdata     = {31'd0, v};
      cycle();
      idle();
   endtask

   task automatic w1c();
      idle();
      bus.wr_INT_ST = 1'b1;
      bus.pstrb     = 4'h1;
      bus.wdata     = 32'h1;
      cycle();
      idle();
   endtask

   initial begin
      int unsigned sel;
      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;
      bus.count = 64'd0;
      idle();
      model_reset();

      #7;
      check_all();
      chk("rst_cmp", bus.cmp, 64'hFFFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      rst_n = 1'b1;

      cycle();
      wr_cmp(1'b0, 4'b0101, 32'h1122_3344);
      chk("cmp_strb_lo", bus.cmp, 64'hFFFF_FFFF_FF22_FF44);
      wr_cmp(1'b1, 4'hF, 32'h0000_0000);
      chk("cmp_strb_hi", bus.cmp, 64'h0000_0000_FF22_FF44);

      // Match sequence at 64'h0000_0001_0000_0010.
      wr_cmp(1'b0, 4'hF, 32'h0000_0010);
      wr_cmp(1'b1, 4'hF, 32'h0000_0001);
      wr_en(1'b1);
      bus.count = 64'h0000_0001_0000_000E;
      cycle();
      bus.count = 64'h0000_0001_0000_000F;
      cycle();
      bus.count = 64'h0000_0001_0000_0010;
      cycle();
      chk("hit_st",  {63'd0, bus.int_st},  64'd1);
      chk("hit_pls", {63'd0, bus.cmp_hit}, 64'd1);
      chk("hit_int", {63'd0, bus.tim_int}, 64'd1);
      bus.count = 64'h0000_0001_0000_000B;
      cycle();
      chk("hit_once", {63'd0, bus.cmp_hit}, 64'd0);
      chk("st_stick", {63'd0, bus.int_st},  64'd1);

      // Masking leaves status alone.
      wr_en(1'b0);
      chk("mask_int", {63'd0, bus.tim_int}, 64'd0);
      chk("mask_st",  {63'd0, bus.int_st},  64'd1);
      wr_en(1'b1);
      chk("unmask_int", {63'd0, bus.tim_int}, 64'd1);

      // W1C without match clears; W1C with match is overridden.
      w1c();
      chk("w1c_clr", {63'd0, bus.int_st}, 64'd0);
      bus.count = 64'h0000_0001_0000_0010;
      cycle();
      bus.wr_INT_ST = 1'b1;
      bus.pstrb     = 4'h1;
      bus.wdata     = 32'h1;
      cycle();
      idle();
      chk("set_beats_clr", {63'd0, bus.int_st}, 64'd1);
      // Writing 0 or without pstrb[0] does nothing.
      bus.count = 64'h0000_0001_0000_0000;
      bus.wr_INT_ST = 1'b1;
      bus.pstrb     = 4'hE;
      bus.wdata     = 32'hFFFF_FFFF;
      cycle();
      idle();
      chk("w1c_nostrb", {63'd0, bus.int_st}, 64'd1);

      // Async reset mid-operation with a pending pulse.
      bus.count = 64'h0000_0001_0000_0010;
      w1c();
      cycle();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("arst_hit", {63'd0, bus.cmp_hit}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Wrap: reset cmp matches all-ones count.
      bus.count = 64'hFFFF_FFFF_FFFF_FFFF;
      cycle();
      chk("wrap_set", {63'd0, bus.int_st}, 64'd1);
      bus.count = 64'd0;
      w1c();
      cycle();

`ifdef TIMER_CMP_GE_EN
      wr_cmp(1'b1, 4'hF, 32'd0);
      wr_cmp(1'b0, 4'hF, 32'd100);
      bus.count = 64'd150;
      cycle();
      chk("ge_set", {63'd0, bus.int_st}, 64'd1);
      w1c();
      chk("ge_reset", {63'd0, bus.int_st}, 64'd1);
      wr_cmp(1'b0, 4'hF, 32'd200);
      w1c();
      chk("ge_clr", {63'd0, bus.int_st}, 64'd0);
      for (int i = 0; i < 4; i++) begin
         bus.count = 64'd150 + 64'(i * 10);
         cycle();
         chk("ge_hold", {63'd0, bus.int_st}, 64'd0);
      end
`endif

      // Randomized phase with count frequently near cmp.
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2: bus.count = m_cmp;
            3:       bus.count = m_cmp - 64'd1;
            4:       bus.count = m_cmp + 64'd1;
            5:       bus.count = {$urandom, $urandom};
            default: bus.count = bus.count + 64'd1;
         endcase
         bus.wr_CMP0   = ($urandom_range(0, 7) == 0);
         bus.wr_CMP1   = ($urandom_range(0, 7) == 0);
         bus.wr_INT_EN = ($urandom_range(0, 5) == 0);
         bus.wr_INT_ST = ($urandom_range(0, 3) == 0);
         bus.pstrb     = 4'($urandom);
         bus.wdata     = ($urandom_range(0, 1) == 1) ? bus.count[31:0] : $urandom;
         cycle();
      end
      idle();
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/timer_cmp_irq.md
# timer_cmp_irq

Compare-and-interrupt stage sitting directly downstream of the 64-bit timer counter. Holds the 64-bit compare value (two 32-bit APB words with byte strobes), compares it each cycle against the live `count` bus, and maintains a sticky interrupt status with write-1-to-clear and an enable mask. Drives the timer interrupt line and supplies readback values to the APB register file.

## Interface
- No parameters; widths fixed at 64-bit compare and 32-bit APB data.
- `clk` input 1: system clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `count` input 64: live counter value from the counter stage.
- `wr_CMP0` input 1: write strobe, compare low word (bits 31:0).
- `wr_CMP1` input 1: write strobe, compare high word (bits 63:32).
- `wr_INT_EN` input 1: write strobe, interrupt enable register.
- `wr_INT_ST` input 1: write strobe, interrupt status register (W1C).
- `pstrb` input 4: APB byte strobes; `pstrb[n]` qualifies `wdata[8n+7:8n]`.
- `wdata` input 32: APB write data.
- `cmp` output 64: current compare register value (readback).
- `int_en` output 1: interrupt enable bit (readback).
- `int_st` output 1: sticky interrupt status bit (readback).
- `cmp_hit` output 1: one-cycle pulse on 0→1 transition of `int_st`.
- `tim_int` output 1: interrupt to core, `int_en & int_st`.

## Operation
- Compare register: reset `64'hFFFF_FFFF_FFFF_FFFF`. `wr_CMP0` updates bytes 0–3 per `pstrb`; `wr_CMP1` updates bytes 4–7 per `pstrb`; unstrobed bytes hold. Both strobes in one cycle: both halves take `wdata` per `pstrb`.
- Enable: reset 0. `wr_INT_EN & pstrb[0]` loads `wdata[0]`; other bits ignored.
- Match: `match = (count == cmp)` using the registered `cmp` (pre-write value in a write cycle); unsigned, full 64 bits.
- Status: reset 0. Next value = `match | (int_st & ~clr)`, where `clr = wr_INT_ST & pstrb[0] & wdata[0]`. Set beats clear in the same cycle. Writing 0 has no effect.
- `cmp_hit`: registered, asserted for the single cycle in which `int_st` first reads 1 after being 0.
- `tim_int`: combinational AND of `int_en` and `int_st`; enable toggling masks/unmasks without altering status.
- Counter wrap (`count` 64'hFFFF_FFFF_FFFF_FFFF → 0) requires no special handling; reset `cmp` matches at all-ones.
- Counter stalled at a matching value: `int_st` re-sets every cycle; clear has no lasting effect until `count` or `cmp` changes.

## Timing
- All outputs 0 in reset except `cmp` = all-ones.
- `count` equal to `cmp` in cycle N → `int_st` = 1 and `cmp_hit` = 1 in cycle N+1; `tim_int` = 1 in N+1 if `int_en` = 1.
- CMP write in cycle N → new `cmp` visible and used for matching from N+1.
- W1C in cycle N with no match → `int_st` = 0 from N+1; `tim_int` drops in N+1.
- `int_en` write in cycle N → `tim_int` reflects it from N+1.
- `rst_n` asserted mid-operation: all registers return to reset values immediately (asynchronously); no pending pulse survives.

## Configuration
- `TIMER_CMP_GE_EN` defined: `match = (count >= cmp)` (unsigned 64-bit). Status re-sets every cycle while count is at or above compare; clear holds only after `cmp` is raised above `count` or the counter wraps.
- Not defined: equality match only, as specified above.

## Test plan
- Reset: assert `rst_n`=0 → `cmp`=64'hFFFF_FFFF_FFFF_FFFF, `int_en`=0, `int_st`=0, `cmp_hit`=0, `tim_int`=0.
- Byte-strobed write: `wr_CMP0`, `pstrb`=4'b0101, `wdata`=32'h1122_3344 → `cmp`=64'hFFFF_FFFF_FF22_FF44 next cycle; `wr_CMP1`, `pstrb`=4'hF, `wdata`=0 → `cmp`=64'h0000_0000_FF22_FF44.
- Match/interrupt: `cmp`=64'h0000_0001_0000_0010, `int_en`=1, `count` steps through 64'h0000_0001_0000_0010 in cycle N → `int_st`=1, `cmp_hit`=1, `tim_int`=1 in N+1; `cmp_hit`=0 in N+2 while `int_st` stays 1.
- W1C and priority: `wr_INT_ST`, `pstrb[0]`=1, `wdata`=1 while no match → `int_st`=0 next cycle; same write in a cycle where `count==cmp` → `int_st` stays 1.
- Masking: `int_st`=1, write `int_en`=0 → `tim_int`=0 next cycle, `int_st` still 1; re-enable → `tim_int`=1.
- With `TIMER_CMP_GE_EN`: `cmp`=100, `count`=150 → `int_st` set; W1C → `int_st` reasserts next cycle; write `cmp`=200 then W1C → `int_st`=0 and stays 0 while `count`<200.
